// File: rtl/plot_pkg.sv
// Shared definitions for the plotter move sequencer: register map, status/control
// bit positions, sequencer states and the queued move entry.
package plot_pkg;

  localparam logic [2:0] REG_DX      = 3'd0;
  localparam logic [2:0] REG_DY_PUSH = 3'd1;
  localparam logic [2:0] REG_PERIOD  = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_CTRL    = 3'd4;
  localparam logic [2:0] REG_POS_X   = 3'd5;
  localparam logic [2:0] REG_POS_Y   = 3'd6;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_COUNT_LSB = 3;
  localparam int ST_OVF       = 8;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_ABORT = 1;

  localparam logic [15:0] PERIOD_RST = 16'd1000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    GAP   = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic signed [15:0] dx;
    logic signed [15:0] dy;
  } move_t;

  // Magnitude of a signed delta; -32768 saturates so the result fits 15 bits.
  function automatic logic [15:0] mag16(input logic signed [15:0] v);
    logic [15:0] r;
    if (v == 16'sh8000) begin
      r = 16'd32767;
    end else if (v < 16'sd0) begin
      r = $unsigned(-v);
    end else begin
      r = $unsigned(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/plot_move_sequencer_move_fifo.sv
// Synchronous FIFO of queued moves with push, pop and flush; a push into a full
// queue is accepted when a pop happens on the same edge.
module move_fifo
  import plot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  move_t      din,
  output move_t      dout,
  output logic [4:0] count,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  move_t          mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [4:0]     count_r;
  logic           push_ok_s;
  logic           pop_ok_s;

  assign full      = (count_r == 5'(DEPTH));
  assign empty     = (count_r == 5'd0);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= 5'd0;
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= 5'd0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/plot_move_sequencer.sv
// APB3 plotter move sequencer: queued relative moves, Bresenham step/dir generation.
// Optional absolute position counters when POS_TRACK_EN is defined.
module plot_move_sequencer
  import plot_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_W    = 8,
  parameter int DIR_SETUP  = 16
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        step1,
  output logic        dir1,
  output logic        step2,
  output logic        dir2
);

  logic               wr_s, rd_setup_s, push_s, pop_s, abort_s, push_drop_s;
  logic [2:0]         addr_s;
  logic               unused_s;
  logic signed [15:0] dx_r;
  logic [15:0]        period_reg_r;
  logic               enable_r, ovf_r;
  logic [31:0]        rdata_r, rd_mux_s;
  move_t              push_entry_s, fifo_dout_s, move_r;
  logic [4:0]         fifo_count_s;
  logic               fifo_full_s, fifo_empty_s;
  seq_state_t         state_r;
  logic [15:0]        cnt_r, remaining_r, major_r, minor_r, period_r;
  logic               x_major_r;
  logic signed [16:0] err_r, err_dec_s, err_next_s;
  logic               err_neg_s, pulse_entry_s, gap_entry_s;
  logic [15:0]        mag_x_s, mag_y_s, major_s, minor_s, eff_period_s;
  logic               x_major_s;
  logic               step1_r, step2_r, dir1_r, dir2_r;

  assign addr_s       = PADDR[4:2];
  assign unused_s     = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:16]};
  assign wr_s         = PSEL & PENABLE & PWRITE;
  assign rd_setup_s   = PSEL & ~PENABLE & ~PWRITE;
  assign push_s       = wr_s & (addr_s == REG_DY_PUSH);
  assign abort_s      = wr_s & (addr_s == REG_CTRL) & PWDATA[CTRL_ABORT];
  assign pop_s        = (state_r == IDLE) & enable_r & ~fifo_empty_s & ~abort_s;
  assign push_drop_s  = push_s & fifo_full_s & ~pop_s;
  assign push_entry_s = '{dx: dx_r, dy: PWDATA[15:0]};

  assign PREADY  = 1'b1;
  assign PSLVERR = push_drop_s;
  assign PRDATA  = rdata_r;
  assign step1   = step1_r;
  assign step2   = step2_r;
  assign dir1    = dir1_r;
  assign dir2    = dir2_r;

  move_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESERN),
    .push  (push_s),
    .pop   (pop_s),
    .flush (abort_s),
    .din   (push_entry_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Move geometry, Bresenham error update and effective step period
  always_comb begin
    mag_x_s   = mag16(move_r.dx);
    mag_y_s   = mag16(move_r.dy);
    x_major_s = (mag_x_s >= mag_y_s);
    if (x_major_s) begin
      major_s = mag_x_s;
      minor_s = mag_y_s;
    end else begin
      major_s = mag_y_s;
      minor_s = mag_x_s;
    end
    err_dec_s = err_r - $signed({1'b0, minor_r});
    err_neg_s = err_dec_s[16];
    if (err_neg_s) begin
      err_next_s = err_dec_s + $signed({1'b0, major_r});
    end else begin
      err_next_s = err_dec_s;
    end
    if (period_reg_r > 16'(PULSE_W)) begin
      eff_period_s = period_reg_r;
    end else begin
      eff_period_s = 16'(PULSE_W + 1);
    end
  end

  assign pulse_entry_s = ~abort_s & (cnt_r == 16'd0) &
                         ((state_r == SETUP) | ((state_r == GAP) & (remaining_r != 16'd0)));
  assign gap_entry_s   = ~abort_s & (cnt_r == 16'd0) & (state_r == PULSE);

  // Register file writes and sticky overflow
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      dx_r         <= 16'sd0;
      period_reg_r <= PERIOD_RST;
      enable_r     <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      if (wr_s && addr_s == REG_DX)     dx_r         <= PWDATA[15:0];
      if (wr_s && addr_s == REG_PERIOD) period_reg_r <= PWDATA[15:0];
      if (wr_s && addr_s == REG_CTRL)   enable_r     <= PWDATA[CTRL_EN];
      if (push_drop_s) begin
        ovf_r <= 1'b1;
      end else if (wr_s && addr_s == REG_STATUS && PWDATA[ST_OVF]) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Sequencer state, move geometry latch and direction outputs
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_r     <= IDLE;
      cnt_r       <= 16'd0;
      remaining_r <= 16'd0;
      major_r     <= 16'd0;
      minor_r     <= 16'd0;
      x_major_r   <= 1'b1;
      move_r      <= '{dx: 16'sd0, dy: 16'sd0};
      dir1_r      <= 1'b0;
      dir2_r      <= 1'b0;
    end else if (abort_s) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            move_r  <= fifo_dout_s;
            state_r <= LOAD;
          end
        end
        LOAD: begin
          major_r     <= major_s;
          minor_r     <= minor_s;
          remaining_r <= major_s;
          x_major_r   <= x_major_s;
          if (move_r.dx > 16'sd0) dir1_r <= 1'b1;
          else if (move_r.dx < 16'sd0) dir1_r <= 1'b0;
          if (move_r.dy > 16'sd0) dir2_r <= 1'b1;
          else if (move_r.dy < 16'sd0) dir2_r <= 1'b0;
          if (major_s == 16'd0) begin
            state_r <= IDLE;
          end else begin
            state_r <= SETUP;
            cnt_r   <= 16'(DIR_SETUP - 1);
          end
        end
        SETUP: begin
          if (cnt_r == 16'd0) begin
            state_r <= PULSE;
            cnt_r   <= 16'(PULSE_W - 1);
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        PULSE: begin
          if (cnt_r == 16'd0) begin
            state_r     <= GAP;
            cnt_r       <= period_r - 16'(PULSE_W + 1);
            remaining_r <= remaining_r - 16'd1;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        GAP: begin
          if (cnt_r == 16'd0) begin
            if (remaining_r == 16'd0) begin
              state_r <= IDLE;
            end else begin
              state_r <= PULSE;
              cnt_r   <= 16'(PULSE_W - 1);
            end
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Step outputs, error term and period sampled at each step rise
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      step1_r  <= 1'b0;
      step2_r  <= 1'b0;
      err_r    <= 17'sd0;
      period_r <= PERIOD_RST;
    end else if (abort_s) begin
      step1_r <= 1'b0;
      step2_r <= 1'b0;
    end else if (state_r == LOAD) begin
      err_r <= $signed({2'b00, major_s[15:1]});
    end else if (pulse_entry_s) begin
      step1_r  <= x_major_r | err_neg_s;
      step2_r  <= ~x_major_r | err_neg_s;
      err_r    <= err_next_s;
      period_r <= eff_period_s;
    end else if (gap_entry_s) begin
      step1_r <= 1'b0;
      step2_r <= 1'b0;
    end
  end

`ifdef POS_TRACK_EN
  logic signed [31:0] pos_x_r, pos_y_r;
  logic               x_step_s, y_step_s;

  assign x_step_s = pulse_entry_s & (x_major_r | err_neg_s);
  assign y_step_s = pulse_entry_s & (~x_major_r | err_neg_s);

  // Absolute position counters; software loads take priority over steps
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      pos_x_r <= 32'sd0;
      pos_y_r <= 32'sd0;
    end else begin
      if (wr_s && addr_s == REG_POS_X) pos_x_r <= PWDATA;
      else if (x_step_s) pos_x_r <= dir1_r ? pos_x_r + 32'sd1 : pos_x_r - 32'sd1;
      if (wr_s && addr_s == REG_POS_Y) pos_y_r <= PWDATA;
      else if (y_step_s) pos_y_r <= dir2_r ? pos_y_r + 32'sd1 : pos_y_r - 32'sd1;
    end
  end
`endif

  // Read data mux
  always_comb begin
    rd_mux_s = 32'd0;
    case (addr_s)
      REG_DX:     rd_mux_s = {16'd0, dx_r};
      REG_PERIOD: rd_mux_s = {16'd0, period_reg_r};
      REG_STATUS: begin
        rd_mux_s[ST_BUSY]              = (state_r != IDLE);
        rd_mux_s[ST_FULL]              = fifo_full_s;
        rd_mux_s[ST_EMPTY]             = fifo_empty_s;
        rd_mux_s[ST_COUNT_LSB +: 5]    = fifo_count_s;
        rd_mux_s[ST_OVF]               = ovf_r;
      end
      REG_CTRL:   rd_mux_s = {31'd0, enable_r};
`ifdef POS_TRACK_EN
      REG_POS_X:  rd_mux_s = pos_x_r;
      REG_POS_Y:  rd_mux_s = pos_y_r;
`endif
      default:    rd_mux_s = 32'd0;
    endcase
  end

  // Read data captured in the setup phase, presented during access
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      rdata_r <= 32'd0;
    end else if (rd_setup_s) begin
      rdata_r <= rd_mux_s;
    end else if (!PSEL) begin
      rdata_r <= 32'd0;
    end
  end

endmodule

// File: tb/tb_plot_move_sequencer.sv
// Directed self-checking bench for plot_move_sequencer (default parameters).
// Position-counter checks are selected by POS_TRACK_EN.
module tb_plot_move_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        step1, dir1, step2, dir2;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  int exp_period = 100;
  int s1_rises, s2_rises, s1_first, s1_last, s2_last, hi1, hi2;
  int period_bad, width_bad, incoh;
  logic p1 = 1'b0, p2 = 1'b0;

  logic [31:0] rd;
  logic        err;
  int          t_push, fr;

  plot_move_sequencer dut (
    .PCLK    (clk),
    .PRESERN (rst_n),
    .PSEL    (psel),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata),
    .PREADY  (pready),
    .PSLVERR (pslverr),
    .step1   (step1),
    .dir1    (dir1),
    .step2   (step2),
    .dir2    (dir2)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled on the inactive edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (step1 && !p1) begin
      s1_rises = s1_rises + 1;
      if (s1_rises == 1) s1_first = cyc;
      else if (cyc - s1_last != exp_period) period_bad = period_bad + 1;
      s1_last = cyc;
      hi1 = 0;
    end
    if (step2 && !p2) begin
      s2_rises = s2_rises + 1;
      s2_last = cyc;
      hi2 = 0;
    end
    if (step1) hi1 = hi1 + 1;
    if (step2) hi2 = hi2 + 1;
    if (!step1 && p1 && hi1 != 8) width_bad = width_bad + 1;
    if (!step2 && p2 && hi2 != 8) width_bad = width_bad + 1;
    if (step2 && !step1) incoh = incoh + 1;
    p1 = step1;
    p2 = step2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    s1_rises = 0; s2_rises = 0; s1_first = 0; s1_last = 0; s2_last = 0;
    period_bad = 0; width_bad = 0; incoh = 0;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
    clear_mon();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_step1", {31'd0, step1}, 32'd0);
    chk("rst_dir1", {31'd0, dir1}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    rst_n = 1'b1;
    apb_read(32'h0C, rd); chk("rst_status", rd, 32'h004);
    apb_read(32'h08, rd); chk("rst_period", rd, 32'd1000);
    apb_read(32'h10, rd); chk("rst_ctrl", rd, 32'd0);

    // Move (3,0) at period 100
    apb_write(32'h08, 32'd100, err);
    apb_write(32'h10, 32'd1, err);
    apb_write(32'h00, 32'd3, err);
    clear_mon();
    apb_write(32'h04, 32'd0, err);
    chk("t1_push_err", {31'd0, err}, 32'd0);
    t_push = cyc;
    wait_until(t_push + 19 + 320);
    chk("t1_first_rise", s1_first, t_push + 19);
    chk("t1_s1_rises", s1_rises, 32'd3);
    chk("t1_s2_rises", s2_rises, 32'd0);
    chk("t1_period_bad", period_bad, 32'd0);
    chk("t1_width_bad", width_bad, 32'd0);
    chk("t1_dir1", {31'd0, dir1}, 32'd1);
    apb_read(32'h0C, rd); chk("t1_status_idle", rd, 32'h004);

    // Move (-4,2)
    apb_write(32'h00, 32'h0000_FFFC, err);
    clear_mon();
    apb_write(32'h04, 32'd2, err);
    t_push = cyc;
    fr = t_push + 19;
    wait_until(fr + 395);
    apb_read(32'h0C, rd); chk("t2_busy_late", rd, 32'h005);
    wait_until(fr + 405);
    apb_read(32'h0C, rd); chk("t2_busy_fell", rd, 32'h004);
    chk("t2_first_rise", s1_first, fr);
    chk("t2_s1_rises", s1_rises, 32'd4);
    chk("t2_s2_rises", s2_rises, 32'd2);
    chk("t2_incoherent", incoh, 32'd0);
    chk("t2_width_bad", width_bad, 32'd0);
    chk("t2_period_bad", period_bad, 32'd0);
    chk("t2_dir1", {31'd0, dir1}, 32'd0);
    chk("t2_dir2", {31'd0, dir2}, 32'd1);

    // Overflow while disabled
    apb_write(32'h10, 32'd0, err);
    apb_write(32'h00, 32'd1, err);
    for (int i = 0; i < 4; i++) apb_write(32'h04, 32'd0, err);
    chk("t3_last_ok_push", {31'd0, err}, 32'd0);
    apb_write(32'h04, 32'd0, err);
    chk("t3_pslverr", {31'd0, err}, 32'd1);
    apb_read(32'h0C, rd); chk("t3_status_ovf", rd, 32'h122);
    apb_write(32'h0C, 32'h100, err);
    apb_read(32'h0C, rd); chk("t3_ovf_cleared", rd, 32'h022);
    apb_write(32'h10, 32'd2, err);
    apb_read(32'h0C, rd); chk("t3_flushed", rd, 32'h004);
    apb_read(32'h10, rd); chk("t3_ctrl_abort_reads0", rd, 32'd0);

    // Null move followed by (1,1)
    apb_write(32'h10, 32'd1, err);
    clear_mon();
    apb_write(32'h00, 32'd0, err);
    apb_write(32'h04, 32'd0, err);
    apb_write(32'h00, 32'd1, err);
    apb_write(32'h04, 32'd1, err);
    wait_until(cyc + 250);
    chk("t4_s1_rises", s1_rises, 32'd1);
    chk("t4_s2_rises", s2_rises, 32'd1);
    chk("t4_coincident", s2_last, s1_last);
    chk("t4_width_bad", width_bad, 32'd0);
    chk("t4_dirs", {30'd0, dir1, dir2}, 32'd3);
    apb_read(32'h0C, rd); chk("t4_status", rd, 32'h004);

    // Abort during PULSE of (10,0)
    clear_mon();
    apb_write(32'h00, 32'd10, err);
    apb_write(32'h04, 32'd0, err);
    for (int i = 0; i < 60 && !step1; i++) @(negedge clk);
    chk("t5_pulse_seen", {31'd0, step1}, 32'd1);
    apb_write(32'h10, 32'd3, err);
    @(negedge clk);
    chk("t5_step1_cut", {31'd0, step1}, 32'd0);
    apb_read(32'h0C, rd); chk("t5_idle_empty", rd, 32'h004);
    chk("t5_dir1_held", {31'd0, dir1}, 32'd1);
    wait_until(cyc + 200);
    chk("t5_no_more_steps", s1_rises, 32'd1);

    // Asynchronous reset mid-move
    apb_write(32'h04, 32'd0, err);
    for (int i = 0; i < 60 && !step1; i++) @(negedge clk);
    chk("t5b_pulse_seen", {31'd0, step1}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5b_rst_steps", {30'd0, step1, step2}, 32'd0);
    chk("t5b_rst_dirs", {30'd0, dir1, dir2}, 32'd0);
    chk("t5b_rst_prdata", prdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apb_read(32'h0C, rd); chk("t5b_status", rd, 32'h004);
    apb_read(32'h08, rd); chk("t5b_period", rd, 32'd1000);
    apb_read(32'h10, rd); chk("t5b_ctrl", rd, 32'd0);

`ifdef POS_TRACK_EN
    apb_write(32'h10, 32'd1, err);
    apb_write(32'h08, 32'd20, err);
    apb_write(32'h00, 32'd5, err);
    apb_write(32'h04, 32'h0000_FFFD, err);
    apb_write(32'h00, 32'h0000_FFFE, err);
    apb_write(32'h04, 32'd1, err);
    wait_until(cyc + 400);
    apb_read(32'h14, rd); chk("t6_pos_x", rd, 32'd3);
    apb_read(32'h18, rd); chk("t6_pos_y", rd, 32'hFFFF_FFFE);
    apb_write(32'h14, 32'd77, err);
    apb_read(32'h14, rd); chk("t6_pos_x_load", rd, 32'd77);
`else
    apb_write(32'h14, 32'd5, err);
    chk("t6_pos_wr_err", {31'd0, err}, 32'd0);
    apb_read(32'h14, rd); chk("t6_pos_x_absent", rd, 32'd0);
    apb_read(32'h18, rd); chk("t6_pos_y_absent", rd, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/plot_move_sequencer.md
# plot_move_sequencer

- APB3 slave that sequences both plotter stepper axes from a small queue of relative line moves.
- Runs Bresenham interpolation so both axes arrive together, and generates timed step/dir pulses at a programmable rate.
- Sits on CoreAPB3 slot 0 behind the MSS master, and drives step1/dir1/step2/dir2 to the motor drivers.

## Interface
- FIFO_DEPTH, 4: move queue entries (power of 2, 2..16)
- PULSE_W, 8: step high time in PCLK cycles (>=1)
- DIR_SETUP, 16: PCLK cycles from dir update to first step rise (>=1)
- PCLK  in  1  fabric clock (FAB_CLK)
- PRESERN  in  1  asynchronous active-low reset (M2F_RESET_N)
- PSEL, PENABLE, PWRITE  in  1  APB3 control
- PADDR  in  32  byte address; only [4:2] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data, valid in access phase
- PREADY  out  1  constant 1
- PSLVERR  out  1  error on rejected push
- step1, dir1  out  1  X axis driver
- step2, dir2  out  1  Y axis driver

## Operation
- Writes take effect on PCLK when PSEL&PENABLE&PWRITE.
- 0x00 DX (W/R): signed dx[15:0] staged.
- 0x04 DY_PUSH (W): signed dy[15:0]; pushes {DX, dy} to FIFO. If full: push dropped, STATUS.ovf set, PSLVERR=1 that access.
- 0x08 PERIOD (R/W): [15:0] rise-to-rise step period; reset 1000. Effective period = max(PERIOD, PULSE_W+1); sampled at every step rise.
- 0x0C STATUS (R): [0] busy (state!=IDLE), [1] full, [2] empty, [7:3] count, [8] ovf sticky. Writing bit 8 =1 clears ovf.
- 0x10 CTRL (R/W): [0] enable (reset 0); [1] abort, self-clearing, reads 0.
- Other addresses: read 0, writes ignored, PSLVERR=0.
- Magnitude: |v|, with -32768 saturating to 32767; major = max(|dx|,|dy|), minor = min; X is major on tie.
- Error register: 17-bit signed, initialised to major>>1.
- States:
  - IDLE: if enable and not empty, pop to LOAD.
  - LOAD: latch magnitudes; dir1 = dx>0, dir2 = dy>0; dir held if that axis delta is 0. If major==0, go to IDLE (null move consumed); else go to SETUP.
  - SETUP: wait DIR_SETUP cycles, then PULSE.
  - PULSE: major axis step=1. On entry, err' = err - minor; if err'<0, minor axis step=1 and err' += major. Hold PULSE_W cycles, then GAP.
  - GAP: steps 0 for period-PULSE_W cycles; remaining--. If remaining==0, go to IDLE, else PULSE.
- Clearing enable mid-move: the current move finishes; the queue is not started again.
- Abort: FIFO flushed, state forced to IDLE next cycle, step outputs 0 immediately (same edge), dir held, ovf unchanged.
- Push and pop in the same cycle: both honoured; a push while full-and-popping is accepted.

## Timing
- Reset values: step1=step2=0, dir1=dir2=0, PRDATA=0, PSLVERR=0, FIFO empty, PERIOD=1000, CTRL=0, ovf=0.
- Outputs are registered, with no combinational path from APB to step/dir.
- Push to first step rise (enabled, previously idle): 3 + DIR_SETUP cycles (push, IDLE pop, LOAD, SETUP).
- Move of N major steps: final GAP ends N*period cycles after the first rise; the next queued move reaches LOAD 2 cycles later.
- Minor axis pulses are coincident with major axis pulses, with identical width.
- Total minor steps equal |minor| exactly.

## Configuration
- POS_TRACK_EN defined: adds two signed 32-bit absolute position counters.
  - X position at 0x14, Y at 0x18 (R); each inc/dec on every step rise per dir.
  - Writing 0x14 or 0x18 loads the value; abort does not clear them.
- Undefined: 0x14/0x18 read 0, writes ignored; no counter logic.

## Structure
- Shared package plot_pkg:
  - register offsets
  - STATUS/CTRL bit indices
  - state enum {IDLE, LOAD, SETUP, PULSE, GAP}
  - move entry typedef {dx, dy} (2x16 signed)
- Sub-module move_fifo: synchronous FIFO of move entries, with push, pop, flush, count, full, empty.
- The APB decode and sequencer stay in the top module.

## Test plan
- Enable, PERIOD=100, push (3,0): three step1 pulses, 8 cycles high, 100 apart; dir1=1; step2 never pulses; first rise 3+16 cycles after push.
- Push (-4,2): step1 ×4 with dir1=0, step2 ×2 with dir2=1, each coincident with a step1 pulse; busy falls after 4×100 cycles.
- Fill FIFO with 4 moves while disabled, push a 5th: PSLVERR=1, ovf=1, count=4; clear ovf via write 0x100 to 0x0C.
- Push (0,0) then (1,1): the null move is consumed without pulses; the next move starts; step1 and step2 pulse together once.
- Abort during PULSE of (10,0): step1 is 0 on the following cycle, FIFO is empty, state is IDLE, dir1 is held; assert PRESERN low mid-move: all outputs at reset values asynchronously.
- POS_TRACK_EN: moves (5,-3) then (-2,1) read X=3, Y=-2.
